// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states
// and the iteration count of the shift-add / restoring-subtract datapath.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam int MD_ITER = 32;

  function automatic logic is_div_op(md_op_e op);
    return op[1];
  endfunction

  // Bit 0 clear marks the signed flavour of both mult and div.
  function automatic logic is_signed_op(md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// CPU-side bundle of the multiply/divide unit: request, move-to and result signals.
// start, mthi and mtlo are only honoured while busy is low; busy acts as an inverted ready.
interface md_sequencer_if import md_pkg::*; #(
  parameter int WIDTH = 32
) ();

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] mt_data;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  state_e           dbg_state;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo, mt_data, flush,
    input  busy, done, div_zero, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo, mt_data, flush,
    output busy, done, div_zero, hi, lo, dbg_state
  );

endinterface

// File: rtl/md_iter_step.sv
// One combinational iteration: shift-add for multiply, restoring trial-subtract for divide.
// rem holds the accumulator (multiply) or partial remainder (divide); wrk holds multiplier or dividend/quotient.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] wrk_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] wrk_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, rem_i} + (wrk_i[0] ? {1'b0, opb_i} : '0);
    shifted = {rem_i, wrk_i[WIDTH-1]};
    diff    = shifted - {1'b0, opb_i};
    rem_o   = rem_i;
    wrk_o   = wrk_i;
    if (is_div_i) begin
      // A kept remainder is always below the divisor, so it fits back in WIDTH bits.
      if (!diff[WIDTH]) begin
        rem_o = diff[WIDTH-1:0];
        wrk_o = {wrk_i[WIDTH-2:0], 1'b1};
      end else begin
        rem_o = shifted[WIDTH-1:0];
        wrk_o = {wrk_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_o = sum[WIDTH:1];
      wrk_o = {sum[0], wrk_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Works on operand magnitudes for ITER cycles, then applies result signs in FIX.
module md_sequencer import md_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ITER  = MD_ITER
) (
  input  logic           clock,
  input  logic           rst_n,
  md_sequencer_if.slave  bus
);

  localparam int CW = $clog2(ITER);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_rem, step_wrk;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_op(op_q)),
    .rem_i    (rem_q),
    .wrk_i    (wrk_q),
    .opb_i    (opb_q),
    .rem_o    (step_rem),
    .wrk_o    (step_wrk)
  );

  always_comb begin
    a_neg    = is_signed_op(bus.op) && bus.src_a[WIDTH-1];
    b_neg    = is_signed_op(bus.op) && bus.src_b[WIDTH-1];
    mag_a    = a_neg ? -bus.src_a : bus.src_a;
    mag_b    = b_neg ? -bus.src_b : bus.src_b;
    prod     = {rem_q, wrk_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -wrk_q : wrk_q;
    rem_fix  = sign_a_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    rem_d      = rem_q;
    wrk_d      = wrk_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d       = bus.op;
          sign_a_d   = a_neg;
          sign_b_d   = b_neg;
          opb_d      = mag_b;
          rem_d      = '0;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          // Multiply is commutative, so src_a doubles as the multiplier shifted out of wrk.
          if (is_div_op(bus.op) && (bus.src_b == '0)) begin
            dz_d    = 1'b1;
            wrk_d   = bus.src_a;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            wrk_d   = mag_a;
            state_d = S_CALC;
          end
        end else begin
          if (bus.mthi) hi_d = bus.mt_data;
          if (bus.mtlo) lo_d = bus.mt_data;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          wrk_d = step_wrk;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (dz_q) begin
            hi_d       = wrk_q;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else if (is_div_op(op_q)) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= MD_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      rem_q      <= '0;
      wrk_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_q       <= dz_d;
      rem_q      <= rem_d;
      wrk_q      <= wrk_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  // A flush seen in DONE suppresses the pulse; HI/LO were already written in FIX.
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE) && !bus.flush;
  assign bus.div_zero  = div_zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: a table of operations with hand-computed HI/LO,
// plus sequences for move-to, flush, busy-time writes and asynchronous reset.
module tb_md_sequencer;
  import md_pkg::*;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } vec_t;

  logic clock;
  logic rst_n;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];
  vec_t vecs[13];

  md_sequencer_if #(.WIDTH(32)) bus ();

  md_sequencer #(.WIDTH(32), .ITER(32)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one start and samples at every falling edge until busy drops (bounded).
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int dcnt, output int dat);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clock);
    bus.start = 1'b0;
    cyc  = 0;
    dcnt = 0;
    dat  = -1;
    while (bus.busy && cyc < 100) begin
      cyc++;
      if (bus.done) begin
        dcnt++;
        dat = cyc;
      end
      @(negedge clock);
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clock);
    bus.mthi    = h;
    bus.mtlo    = l;
    bus.mt_data = d;
    @(negedge clock);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
  endtask

  initial begin
    int cyc, dcnt, dat;
    int seen_done;
    logic [63:0] e;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = MD_MULT; bus.src_a = '0; bus.src_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = '0; bus.flush = 1'b0;

    vecs[0]  = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[3]  = '{MD_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[5]  = '{MD_DIVU,  32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'h2AAA_AAAA, 1'b0, 34};
    vecs[6]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
    vecs[7]  = '{MD_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 34};
    vecs[8]  = '{MD_DIV,   32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 34};
    vecs[9]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[10] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 34};
    vecs[11] = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
    vecs[12] = '{MD_DIVU,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};

    repeat (2) @(negedge clock);
    check("reset_hi", {32'h0, bus.hi}, 64'h0);
    check("reset_lo", {32'h0, bus.lo}, 64'h0);
    check("reset_busy", {63'h0, bus.busy}, 64'h0);
    check("reset_done", {63'h0, bus.done}, 64'h0);
    check("reset_dz", {63'h0, bus.div_zero}, 64'h0);
    check("reset_state", {62'h0, bus.dbg_state}, {62'h0, S_IDLE});
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      exp_q.push_back({vecs[i].hi, vecs[i].lo});
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, dcnt, dat);
      e = exp_q.pop_front();
      check($sformatf("v%0d_hi", i), {32'h0, bus.hi}, {32'h0, e[63:32]});
      check($sformatf("v%0d_lo", i), {32'h0, bus.lo}, {32'h0, e[31:0]});
      check($sformatf("v%0d_dz", i), {63'h0, bus.div_zero}, {63'h0, vecs[i].dz});
      check($sformatf("v%0d_busy_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_done_pulses", i), 64'(dcnt), 64'd1);
      check($sformatf("v%0d_done_last", i), 64'(dat), 64'(vecs[i].cyc));
    end

    // Move-to writes in IDLE land on the next edge; both set writes both.
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    check("mthi_hi", {32'h0, bus.hi}, 64'h1234);
    mt_write(1'b0, 1'b1, 32'h0000_5678);
    check("mtlo_lo", {32'h0, bus.lo}, 64'h5678);
    check("mtlo_hi_kept", {32'h0, bus.hi}, 64'h1234);
    mt_write(1'b1, 1'b1, 32'h0000_AAAA);
    check("mtboth_hi", {32'h0, bus.hi}, 64'hAAAA);
    check("mtboth_lo", {32'h0, bus.lo}, 64'hAAAA);

    // mtlo while busy is dropped.
    mt_write(1'b1, 1'b1, 32'h0000_5678);
    @(negedge clock);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.src_a = 32'd2; bus.src_b = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    bus.mtlo = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.mtlo = 1'b0;
    check("busy_mtlo_lo", {32'h0, bus.lo}, 64'h5678);
    cyc = 0;
    while (bus.busy && cyc < 100) begin cyc++; @(negedge clock); end
    check("busy_mtlo_result_lo", {32'h0, bus.lo}, 64'h6);

    // start together with mthi: the operation wins.
    mt_write(1'b1, 1'b1, 32'h0000_1234);
    @(negedge clock);
    bus.start = 1'b1; bus.mthi = 1'b1; bus.mt_data = 32'hBEEF;
    bus.op = MD_MULTU; bus.src_a = 32'd2; bus.src_b = 32'd3;
    @(negedge clock);
    bus.start = 1'b0; bus.mthi = 1'b0;
    check("start_mthi_hi_dropped", {32'h0, bus.hi}, 64'h1234);
    check("start_mthi_busy", {63'h0, bus.busy}, 64'h1);
    cyc = 0;
    while (bus.busy && cyc < 100) begin cyc++; @(negedge clock); end
    check("start_mthi_hi", {32'h0, bus.hi}, 64'h0);
    check("start_mthi_lo", {32'h0, bus.lo}, 64'h6);

    // start with flush in IDLE is ignored.
    @(negedge clock);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MULT;
    @(negedge clock);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idle_flush_start_busy", {63'h0, bus.busy}, 64'h0);

    // Flush at CALC cycle 10: back to IDLE next cycle, HI/LO untouched, no done.
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    mt_write(1'b0, 1'b1, 32'h0000_5678);
    @(negedge clock);
    bus.start = 1'b1; bus.op = MD_MULT; bus.src_a = 32'd5; bus.src_b = 32'd6;
    @(negedge clock);
    bus.start = 1'b0;
    seen_done = 0;
    repeat (9) begin
      if (bus.done) seen_done++;
      @(negedge clock);
    end
    check("flush_pre_state", {62'h0, bus.dbg_state}, {62'h0, S_CALC});
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    check("flush_busy", {63'h0, bus.busy}, 64'h0);
    repeat (40) begin
      if (bus.done || bus.busy) seen_done++;
      @(negedge clock);
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hi", {32'h0, bus.hi}, 64'h1234);
    check("flush_lo", {32'h0, bus.lo}, 64'h5678);

    // Asynchronous reset mid-CALC clears everything without waiting for a clock edge.
    @(negedge clock);
    bus.start = 1'b1; bus.op = MD_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    bus.start = 1'b1; bus.op = MD_MULT; bus.src_a = 32'd5; bus.src_b = 32'd6;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    check("pre_reset_busy", {63'h0, bus.busy}, 64'h1);
    check("pre_reset_dz", {63'h0, bus.div_zero}, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hi", {32'h0, bus.hi}, 64'h0);
    check("async_rst_lo", {32'h0, bus.lo}, 64'h0);
    check("async_rst_busy", {63'h0, bus.busy}, 64'h0);
    check("async_rst_done", {63'h0, bus.done}, 64'h0);
    check("async_rst_state", {62'h0, bus.dbg_state}, {62'h0, S_IDLE});
    @(negedge clock);
    rst_n = 1'b1;

    // div-by-zero flag is sticky and cleared by the next accepted start.
    run_op(MD_DIV, 32'd9, 32'd0, cyc, dcnt, dat);
    check("dz_set", {63'h0, bus.div_zero}, 64'h1);
    mt_write(1'b1, 1'b0, 32'h0000_0001);
    check("dz_sticky", {63'h0, bus.div_zero}, 64'h1);
    @(negedge clock);
    bus.start = 1'b1; bus.op = MD_DIVU; bus.src_a = 32'd9; bus.src_b = 32'd2;
    @(negedge clock);
    bus.start = 1'b0;
    check("dz_cleared", {63'h0, bus.div_zero}, 64'h0);
    cyc = 0;
    while (bus.busy && cyc < 100) begin cyc++; @(negedge clock); end
    check("divu9_2_hi", {32'h0, bus.hi}, 64'h1);
    check("divu9_2_lo", {32'h0, bus.lo}, 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
